int_ctl: RTL and testbench

INT_CTL -- requirements
Module: int_ctl

---
 rtl/int_ctl.sv | 107 ++++++++++
 tb/tb_int_ctl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctl.sv
// Single-level vectored interrupt controller: edge-latched pending bits, a mask,
// fixed lowest-index priority and an IDLE/FIRE/SERVICE handshake with the CPU.
module int_ctl #(
  parameter logic [31:0] VBASE = 32'h00000080,
  parameter int          NIRQ  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NIRQ-1:0] irq,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wd,
  input  logic [31:0]     pc_in,
  input  logic            eret,
  output logic            INT,
  output logic [31:0]     entryPoint,
  output logic [2:0]      cause,
  output logic [31:0]     epc,
  output logic            busy,
  output logic [NIRQ-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NIRQ-1:0] irq_q;
  logic [NIRQ-1:0] pending_q, pending_d;
  logic [NIRQ-1:0] mask_q, mask_d;
  logic [2:0]      cause_q, cause_d;
  logic [31:0]     epc_q, epc_d;

  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] eligible;
  logic [NIRQ-1:0] clr;
  logic [2:0]      winner;
  logic            take;

  assign rise     = irq & ~irq_q;
  assign eligible = pending_q & mask_q;
  assign take     = (state_q == IDLE) && (eligible != '0);

  // Scan high-to-low so the lowest set index is the last one written.
  always_comb begin
    winner = 3'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = i[2:0];
    end
  end

  always_comb begin
    clr = '0;
    if (take) clr[winner] = 1'b1;
  end

  // A new edge on the line being cleared must survive, so the set is OR'd last.
  always_comb begin
    pending_d = (pending_q & ~clr) | rise;
    mask_d    = mask_we ? mask_wd : mask_q;
    cause_d   = take ? winner : cause_q;
    epc_d     = take ? pc_in : epc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      cause_q   <= 3'd0;
      epc_q     <= 32'd0;
    end else begin
      irq_q     <= irq;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (eligible != '0) state_d = FIRE;
      FIRE:    state_d = SERVICE;
      SERVICE: if (eret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    INT  = (state_q == FIRE);
    busy = (state_q == FIRE) || (state_q == SERVICE);
  end

  assign entryPoint = VBASE + {26'd0, cause_q, 3'b000};
  assign cause      = cause_q;
  assign epc        = epc_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_int_ctl.sv
// Bench for int_ctl: directed scenarios followed by random traffic, all checked
// cycle by cycle against a behavioural model of the controller's rules.
module tb_int_ctl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  irq;
  logic        mask_we;
  logic [7:0]  mask_wd;
  logic [31:0] pc_in;
  logic        eret;
  logic        INT;
  logic [31:0] entryPoint;
  logic [2:0]  cause;
  logic [31:0] epc;
  logic        busy;
  logic [7:0]  pending;

  int_ctl #(.VBASE(32'h00000080), .NIRQ(8)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .mask_we(mask_we), .mask_wd(mask_wd),
    .pc_in(pc_in), .eret(eret), .INT(INT), .entryPoint(entryPoint),
    .cause(cause), .epc(epc), .busy(busy), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Model: mode 0 = waiting, 1 = announcing the interrupt, 2 = handler running.
  bit [7:0]  m_prev;
  bit [7:0]  m_pend;
  bit [7:0]  m_mask;
  int        m_mode;
  int        m_cause;
  bit [31:0] m_epc;

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_mask = '0; m_mode = 0; m_cause = 0; m_epc = '0;
  endtask

  task automatic model_edge();
    int w;
    int nmode;
    bit [7:0] np;
    np = m_pend;
    w = lowest(m_pend & m_mask);
    nmode = m_mode;
    if (m_mode == 0 && w >= 0) begin
      np[w] = 1'b0;
      m_cause = w;
      m_epc = pc_in;
      nmode = 1;
    end else if (m_mode == 1) begin
      nmode = 2;
    end else if (m_mode == 2 && eret) begin
      nmode = 0;
    end
    for (int i = 0; i < 8; i++) if (irq[i] && !m_prev[i]) np[i] = 1'b1;
    if (mask_we) m_mask = mask_wd;
    m_prev = irq;
    m_pend = np;
    m_mode = nmode;
  endtask

  task automatic compare_all();
    chk("INT",        {31'd0, INT},  {31'd0, m_mode == 1});
    chk("busy",       {31'd0, busy}, {31'd0, m_mode != 0});
    chk("pending",    {24'd0, pending}, {24'd0, m_pend});
    chk("cause",      {29'd0, cause}, m_cause);
    chk("epc",        epc, m_epc);
    chk("entryPoint", entryPoint, 32'h00000080 + m_cause * 8);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we = 1'b1; mask_wd = m;
    step();
    mask_we = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    step();
    eret = 1'b0;
  endtask

  int int_cnt;

  initial begin
    rst_n = 1'b0; irq = '0; mask_we = 1'b0; mask_wd = '0; pc_in = '0; eret = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    compare_all();
    chk("rst_entry", entryPoint, 32'h00000080);
    rst_n = 1'b1;
    step();

    // Single request on line 3.
    write_mask(8'hFF);
    pc_in = 32'h00001234;
    irq[3] = 1'b1;
    step();
    chk("l3_pend", {24'd0, pending}, 32'h08);
    step();
    chk("l3_int", {31'd0, INT}, 32'd1);
    chk("l3_cause", {29'd0, cause}, 32'd3);
    chk("l3_entry", entryPoint, 32'h00000098);
    chk("l3_epc", epc, 32'h00001234);
    pc_in = 32'h0000AAAA;
    step();
    chk("l3_int_drop", {31'd0, INT}, 32'd0);
    step(); step();
    chk("l3_busy", {31'd0, busy}, 32'd1);
    do_eret();
    chk("l3_idle", {31'd0, busy}, 32'd0);
    irq = '0;
    step();

    // Simultaneous requests on lines 5 and 2.
    irq = 8'h24;
    step(); step();
    chk("pri_first", {29'd0, cause}, 32'd2);
    step(); step();
    do_eret();
    chk("pri_gap", {31'd0, INT}, 32'd0);
    step();
    chk("pri_second_int", {31'd0, INT}, 32'd1);
    chk("pri_second", {29'd0, cause}, 32'd5);
    step();
    do_eret();
    irq = '0;
    step();

    // Masked request released by a mask write.
    write_mask(8'h00);
    irq[1] = 1'b1;
    step();
    step(); step();
    chk("mask_hold", {24'd0, pending}, 32'h02);
    chk("mask_noint", {31'd0, INT}, 32'd0);
    write_mask(8'h02);
    step();
    chk("mask_int", {31'd0, INT}, 32'd1);
    chk("mask_cause", {29'd0, cause}, 32'd1);
    step();
    do_eret();
    irq = '0;
    write_mask(8'hFF);

    // Request arriving while the handler runs.
    irq[6] = 1'b1;
    step(); step(); step();
    irq[0] = 1'b1;
    step();
    chk("nest_noint", {31'd0, INT}, 32'd0);
    chk("nest_pend", {31'd0, pending[0]}, 32'd1);
    step();
    do_eret();
    step();
    chk("nest_cause", {29'd0, cause}, 32'd0);
    chk("nest_int", {31'd0, INT}, 32'd1);
    step();
    do_eret();
    irq = '0;
    step();

    // Asynchronous reset while announcing.
    irq[1] = 1'b1;
    irq[7] = 1'b1;
    step(); step();
    chk("ar_fire", {31'd0, INT}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_int", {31'd0, INT}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_pend", {24'd0, pending}, 32'd0);
    chk("ar_entry", entryPoint, 32'h00000080);
    compare_all();
    irq = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    write_mask(8'hFF);

    // Stray eret in idle, then a level-held line.
    do_eret();
    chk("eret_idle", {31'd0, busy}, 32'd0);
    int_cnt = 0;
    irq[4] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (INT) int_cnt++;
    end
    chk("level_once", int_cnt, 32'd1);
    do_eret();
    step(); step();
    chk("level_rearm", {31'd0, busy}, 32'd0);
    irq = '0;
    step();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 9) == 0) irq[b] = ~irq[b];
      mask_we = ($urandom_range(0, 15) == 0);
      mask_wd = 8'($urandom);
      pc_in   = $urandom;
      eret    = (m_mode != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
